// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus transmit sequencer between the LSU UART store path and the UART transmitter.
// Optional macro UART_TX_CRLF_EN: a queued 8'h0A goes out as two frames, 8'h0D then 8'h0A.
module uart_tx_buffer #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [7:0]        wr_data_i,
  input  logic              clr_i,
  input  logic              tx_busy_i,
  output logic              tx_transmit_o,
  output logic [7:0]        tx_byte_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              timeout_o,
  output logic              idle_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
`ifdef UART_TX_CRLF_EN
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               idle_q, idle_d;
  logic               tx_transmit_q, tx_transmit_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
`ifdef UART_TX_CRLF_EN
  logic               cr_sent_q, cr_sent_d;
`endif

  logic               pop;
  logic               push;
  logic               mem_we;
  logic [7:0]         head;

  assign head   = mem_q[rd_ptr_q];
  assign mem_we = push && !clr_i;

  // Storage array carries no reset; only pointers define valid contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Sequencer and FIFO bookkeeping next-state logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    timeout_d     = timeout_q;
    tx_transmit_d = 1'b0;
    tx_byte_d     = tx_byte_q;
    tmo_cnt_d     = tmo_cnt_q;
`ifdef UART_TX_CRLF_EN
    cr_sent_d     = cr_sent_q;
`endif
    pop           = 1'b0;
    push          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty_q && !tx_busy_i) begin
          tx_transmit_d = 1'b1;
          state_d       = ST_SEND;
`ifdef UART_TX_CRLF_EN
          // LF stays queued while its leading CR frame is in flight.
          if (head == CHAR_LF && !cr_sent_q) begin
            tx_byte_d = CHAR_CR;
            cr_sent_d = 1'b1;
          end else begin
            pop       = 1'b1;
            tx_byte_d = head;
            cr_sent_d = 1'b0;
          end
`else
          pop       = 1'b1;
          tx_byte_d = head;
`endif
        end
      end
      ST_SEND: begin
        tmo_cnt_d = TMO_W'(1);
        state_d   = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_LO;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    push = wr_en_i && (!full_q || pop);

    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
`ifdef UART_TX_CRLF_EN
      cr_sent_d  = 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (wr_en_i && !push) begin
        overflow_d = 1'b1;
      end
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    idle_d  = (state_d == ST_IDLE) && empty_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      idle_q        <= 1'b1;
      tx_transmit_q <= 1'b0;
      tx_byte_q     <= 8'h00;
      tmo_cnt_q     <= '0;
`ifdef UART_TX_CRLF_EN
      cr_sent_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      idle_q        <= idle_d;
      tx_transmit_q <= tx_transmit_d;
      tx_byte_q     <= tx_byte_d;
      tmo_cnt_q     <= tmo_cnt_d;
`ifdef UART_TX_CRLF_EN
      cr_sent_q     <= cr_sent_d;
`endif
    end
  end

  assign tx_transmit_o = tx_transmit_q;
  assign tx_byte_o     = tx_byte_q;
  assign count_o       = count_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;
  assign idle_o        = idle_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: pushes checked against a queue model with arithmetic pulse timing
// (pulse edge = max(push edge + 1, previous pulse + frame gap, external-busy release)).
module tb_uart_tx_buffer;
  localparam int unsigned ADDR_W = 4;
  localparam int BT = 15;

  logic clk, rst_n, wr_en, clr, ext_busy, model_busy, tx_busy, tx_transmit;
  logic [7:0] wr_data, tx_byte;
  logic [ADDR_W:0] count;
  logic empty, full, overflow, timeout, idle;

  int cyc = 0;
  int tot = 0;
  int bad = 0;
  int frame_len = 20;
  int busy_left = 0;
  int release_edge = 0;
  bit xmit_en = 1'b1;

  typedef struct { logic [7:0] b; int t; } pulse_t;
  pulse_t pulses[$];
  logic [7:0] exp_b[$];
  int exp_a[$];
  bit exp_pop[$];
  int exp_t[$];
  int push_edges[$];
  logic [ADDR_W:0] cnt_hist [int];

  uart_tx_buffer #(.ADDR_W(ADDR_W), .BUSY_TIMEOUT(BT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data), .clr_i(clr),
    .tx_busy_i(tx_busy), .tx_transmit_o(tx_transmit), .tx_byte_o(tx_byte), .count_o(count),
    .empty_o(empty), .full_o(full), .overflow_o(overflow), .timeout_o(timeout), .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = model_busy | ext_busy;

  // Transmitter model: busy rises the cycle after a pulse and stays high frame_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else if (model_busy) begin
      if (busy_left <= 1) model_busy <= 1'b0;
      else busy_left <= busy_left - 1;
    end else if (tx_transmit && xmit_en) begin
      model_busy <= 1'b1;
      busy_left  <= frame_len;
    end
  end

  always @(negedge clk) begin
    if (tx_transmit === 1'b1) pulses.push_back('{b: tx_byte, t: cyc});
    cnt_hist[cyc] = count;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic push_byte(input logic [7:0] b, output int a);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    a = cyc;
    wr_en = 1'b0;
  endtask

  task automatic clear_model();
    pulses.delete(); exp_b.delete(); exp_a.delete(); exp_pop.delete();
    exp_t.delete(); push_edges.delete();
    release_edge = 0;
  endtask

  task automatic expect_add(input logic [7:0] b, input int a);
`ifdef UART_TX_CRLF_EN
    if (b == 8'h0A) begin
      exp_b.push_back(8'h0D); exp_a.push_back(a); exp_pop.push_back(1'b0);
    end
`endif
    exp_b.push_back(b); exp_a.push_back(a); exp_pop.push_back(1'b1);
    push_edges.push_back(a);
  endtask

  task automatic model_times(input int gap);
    int prev = -1000000;
    exp_t.delete();
    foreach (exp_b[i]) begin
      int t = exp_a[i] + 1;
      if (t < release_edge) t = release_edge;
      if (prev + gap > t) t = prev + gap;
      exp_t.push_back(t);
      prev = t;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr = 1'b0; ext_busy = 1'b0;
    tick(3);
    tot++; if (tx_transmit !== 1'b0 || tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx got=%b/%h exp=0/00", tx_transmit, tx_byte); end
    tot++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_level got=%0d/%b/%b exp=0/1/0", count, empty, full); end
    tot++; if (overflow !== 1'b0 || timeout !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL reset_status got=%b/%b/%b exp=0/0/1", overflow, timeout, idle); end
    rst_n = 1'b1;
    tick(3);
    tot++; if (idle !== 1'b1 || tx_transmit !== 1'b0) begin bad++; $display("FAIL post_reset got=%b/%b exp=1/0", idle, tx_transmit); end
  endtask

  task automatic test_single();
    int a;
    clear_model(); frame_len = 20;
    push_byte(8'h41, a);
    expect_add(8'h41, a);
    model_times(frame_len + 3);
    wait_until(exp_t[0] + frame_len + 1);
    tot++; if (idle !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
    tick(1);
    tot++; if (idle !== 1'b1 || count !== '0) begin bad++; $display("FAIL single_idle_back got=%b/%0d exp=1/0", idle, count); end
    tot++; if (tx_byte !== 8'h41) begin bad++; $display("FAIL single_byte_hold got=%h exp=41", tx_byte); end
    tot++; if (pulses.size() != 1) begin bad++; $display("FAIL single_npulses got=%0d exp=1", pulses.size()); end
    else begin
      tot++; if (pulses[0].b !== 8'h41 || pulses[0].t != a + 1) begin bad++; $display("FAIL single_pulse got=%h@%0d exp=41@%0d", pulses[0].b, pulses[0].t, a + 1); end
    end
  endtask

  task automatic test_full_pop_push();
    int a;
    clear_model(); frame_len = 20;
    ext_busy = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i), a);
      expect_add(8'(i), a);
    end
    tot++; if (count !== 5'd16 || full !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL full_level got=%0d/%b/%b exp=16/1/0", count, full, empty); end
    ext_busy = 1'b0;
    push_byte(8'h10, a);
    release_edge = a;
    expect_add(8'h10, a);
    tot++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL full_push_pop got=%0d/%b/%b exp=16/1/0", count, full, overflow); end
    model_times(frame_len + 3);
    wait_until(exp_t[$] + frame_len + 6);
    tot++; if (pulses.size() != exp_b.size()) begin bad++; $display("FAIL full_npulses got=%0d exp=%0d", pulses.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < pulses.size(); i++) begin
      tot++;
      if (pulses[i].b !== exp_b[i] || pulses[i].t != exp_t[i]) begin
        bad++; $display("FAIL full_pulse%0d got=%h@%0d exp=%h@%0d", i, pulses[i].b, pulses[i].t, exp_b[i], exp_t[i]);
      end
    end
    tot++; if (idle !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b/%b exp=1/1", idle, empty); end
  endtask

  task automatic test_overflow();
    int a;
    logic [7:0] b;
    clear_model(); frame_len = 4;
    ext_busy = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      push_byte(b, a);
      expect_add(b, a);
    end
    tot++; if (overflow !== 1'b0 || full !== 1'b1) begin bad++; $display("FAIL ovf_before got=%b/%b exp=0/1", overflow, full); end
    push_byte(8'hEE, a);
    tot++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_drop got=%b/%0d exp=1/16", overflow, count); end
    ext_busy = 1'b0;
    tick(1);
    release_edge = cyc;
    model_times(frame_len + 3);
    wait_until(exp_t[$] + frame_len + 6);
    tot++; if (pulses.size() != exp_b.size()) begin bad++; $display("FAIL ovf_npulses got=%0d exp=%0d", pulses.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < pulses.size(); i++) begin
      tot++;
      if (pulses[i].b !== exp_b[i] || pulses[i].t != exp_t[i]) begin
        bad++; $display("FAIL ovf_pulse%0d got=%h@%0d exp=%h@%0d", i, pulses[i].b, pulses[i].t, exp_b[i], exp_t[i]);
      end
    end
    tot++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr = 1'b1; tick(1); clr = 1'b0;
    tot++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_timeout();
    int a0, a1;
    logic [7:0] b0, b1;
    clear_model(); xmit_en = 1'b0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    push_byte(b0, a0); expect_add(b0, a0);
    push_byte(b1, a1); expect_add(b1, a1);
    model_times(BT + 1);
    wait_until(exp_t[0] + BT - 1);
    tot++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", timeout); end
    tick(1);
    tot++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_edge got=%b exp=1", timeout); end
    wait_until(exp_t[$] + BT + 4);
    tot++; if (pulses.size() != exp_b.size()) begin bad++; $display("FAIL tmo_npulses got=%0d exp=%0d", pulses.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < pulses.size(); i++) begin
      tot++;
      if (pulses[i].b !== exp_b[i] || pulses[i].t != exp_t[i]) begin
        bad++; $display("FAIL tmo_pulse%0d got=%h@%0d exp=%h@%0d", i, pulses[i].b, pulses[i].t, exp_b[i], exp_t[i]);
      end
    end
    clr = 1'b1; tick(1); clr = 1'b0;
    tot++; if (timeout !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL tmo_clr got=%b/%b exp=0/1", timeout, idle); end
    xmit_en = 1'b1;
  endtask

  task automatic test_clr_midframe();
    int a, a0;
    clear_model(); frame_len = 20;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h60 + 8'(i), a);
      if (i == 0) a0 = a;
    end
    expect_add(8'h60, a0);
    model_times(frame_len + 3);
    tot++; if (count !== 5'd4) begin bad++; $display("FAIL clr_prefill got=%0d exp=4", count); end
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick(1);
    clr = 1'b0; wr_en = 1'b0;
    tot++; if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL clr_flush got=%0d/%b/%b exp=0/1/0", count, empty, overflow); end
    tot++; if (idle !== 1'b0) begin bad++; $display("FAIL clr_inflight got=%b exp=0", idle); end
    wait_until(exp_t[0] + frame_len + 2);
    tot++; if (idle !== 1'b1) begin bad++; $display("FAIL clr_complete got=%b exp=1", idle); end
    tick(30);
    tot++; if (pulses.size() != 1) begin bad++; $display("FAIL clr_npulses got=%0d exp=1", pulses.size()); end
    else begin
      tot++; if (pulses[0].b !== 8'h60 || pulses[0].t != exp_t[0]) begin bad++; $display("FAIL clr_pulse got=%h@%0d exp=60@%0d", pulses[0].b, pulses[0].t, exp_t[0]); end
    end
  endtask

  task automatic test_crlf();
    int a;
    clear_model(); frame_len = 6;
    push_byte(8'h0A, a); expect_add(8'h0A, a);
    push_byte(8'h42, a); expect_add(8'h42, a);
    model_times(frame_len + 3);
    wait_until(exp_t[$] + frame_len + 6);
    tot++; if (pulses.size() != exp_b.size()) begin bad++; $display("FAIL crlf_npulses got=%0d exp=%0d", pulses.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < pulses.size(); i++) begin
      tot++;
      if (pulses[i].b !== exp_b[i] || pulses[i].t != exp_t[i]) begin
        bad++; $display("FAIL crlf_pulse%0d got=%h@%0d exp=%h@%0d", i, pulses[i].b, pulses[i].t, exp_b[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_random();
    int a, g, end_cyc, occ;
    logic [7:0] b;
    logic [ADDR_W:0] exp_cnt;
    for (int r = 0; r < 3; r++) begin
      clear_model();
      frame_len = $urandom_range(2, 8);
      for (int i = 0; i < 8; i++) begin
        g = $urandom_range(0, 20);
        if (g > 0) tick(g);
        b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
        push_byte(b, a);
        expect_add(b, a);
      end
      model_times(frame_len + 3);
      end_cyc = exp_t[$] + frame_len + 6;
      wait_until(end_cyc);
      tot++; if (pulses.size() != exp_b.size()) begin bad++; $display("FAIL rnd%0d_npulses got=%0d exp=%0d", r, pulses.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < pulses.size(); i++) begin
        tot++;
        if (pulses[i].b !== exp_b[i] || pulses[i].t != exp_t[i]) begin
          bad++; $display("FAIL rnd%0d_pulse%0d got=%h@%0d exp=%h@%0d", r, i, pulses[i].b, pulses[i].t, exp_b[i], exp_t[i]);
        end
      end
      for (int e = push_edges[0]; e < end_cyc; e++) begin
        occ = 0;
        foreach (push_edges[k]) if (push_edges[k] <= e) occ++;
        foreach (exp_t[k]) if (exp_pop[k] && exp_t[k] <= e) occ--;
        exp_cnt = occ[ADDR_W:0];
        tot++;
        if (!cnt_hist.exists(e) || cnt_hist[e] !== exp_cnt) begin
          bad++; $display("FAIL rnd%0d_count@%0d got=%0d exp=%0d", r, e, cnt_hist.exists(e) ? cnt_hist[e] : 'x, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int a;
    clear_model(); frame_len = 20;
    push_byte(8'h33, a);
    wait_until(a + 4);
    rst_n = 1'b0;
    #2;
    tot++; if (idle !== 1'b1 || tx_transmit !== 1'b0 || count !== '0) begin bad++; $display("FAIL rst_mid got=%b/%b/%0d exp=1/0/0", idle, tx_transmit, count); end
    tick(1);
    rst_n = 1'b1;
    tick(30);
    tot++; if (pulses.size() != 1 || idle !== 1'b1) begin bad++; $display("FAIL rst_mid_after got=%0d/%b exp=1/1", pulses.size(), idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_pop_push();
    test_overflow();
    test_timeout();
    test_clr_midframe();
    test_crlf();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
